dmem_block_responder: RTL and testbench

- Memory-side responder for the data cache's block interface (MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA/MEM_READDATA/MEM_BUSYWAIT).
- Stores 64 blocks of 32 bits (4 bytes per block, 256 bytes total).
- Serves one block read or block write at a time, with a programmable fixed latency.
- Holds the cache stalled through BUSYWAIT until the access completes. It drops into the testbench in place of the main-memory model behind dcache.

---
 rtl/dmem_block_responder.sv | 139 +++++++++++++
 tb/tb_dmem_block_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_block_responder.sv
// dmem_block_responder: memory-side responder for the data cache block port.
// Holds 2**BLOCK_ADDR_W blocks of 32 bits and serves one read or write at a time.
// Each access takes a fixed LATENCY edges (1..15), and BUSYWAIT holds the cache
// stalled until the access completes.
// Optional build macro DMEM_STATS_EN adds saturating read, write and stall counters.
module dmem_block_responder #(
  parameter int LATENCY      = 5,
  parameter int BLOCK_ADDR_W = 6
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    READ,
  input  logic                    WRITE,
  input  logic [BLOCK_ADDR_W-1:0] ADDRESS,
  input  logic [31:0]             WRITEDATA,
  output logic [31:0]             READDATA,
  output logic                    BUSYWAIT
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]             RD_COUNT,
  output logic [15:0]             WR_COUNT,
  output logic [15:0]             STALL_COUNT
`endif
);

  localparam int         DEPTH      = 1 << BLOCK_ADDR_W;
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              counter;
  logic [BLOCK_ADDR_W-1:0] cap_addr;
  logic [31:0]             cap_data;
  logic                    cap_read;
  logic                    start;
  logic                    commit;
  logic                    busy;
  logic [31:0]             mem [DEPTH];

  // Next-state and control decode. The stall in IDLE follows the request combinationally.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    commit     = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        busy = READ | WRITE;
        if (READ | WRITE) begin
          start      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (counter == 4'd0) begin
          commit     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The stall is forced low while RESET is high, because the request may still be raised.
  assign BUSYWAIT = busy & ~RESET;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture, latency countdown, memory array and read data register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      counter  <= 4'd0;
      cap_addr <= '0;
      cap_data <= 32'h0;
      cap_read <= 1'b0;
      READDATA <= 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else begin
      if (start) begin
        cap_addr <= ADDRESS;
        cap_data <= WRITEDATA;
        cap_read <= READ;
        counter  <= COUNT_LOAD;
      end else if (state == ACCESS && counter != 4'd0) begin
        counter <= counter - 4'd1;
      end
      if (commit) begin
        if (cap_read) begin
          READDATA <= mem[cap_addr];
        end else begin
          mem[cap_addr] <= cap_data;
        end
      end
    end
  end

`ifdef DMEM_STATS_EN
  // Saturating counters for completed reads, completed writes and stalled edges.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RD_COUNT    <= 16'h0;
      WR_COUNT    <= 16'h0;
      STALL_COUNT <= 16'h0;
    end else begin
      if (commit && cap_read && RD_COUNT != 16'hFFFF) begin
        RD_COUNT <= RD_COUNT + 16'h1;
      end
      if (commit && !cap_read && WR_COUNT != 16'hFFFF) begin
        WR_COUNT <= WR_COUNT + 16'h1;
      end
      if (BUSYWAIT && STALL_COUNT != 16'hFFFF) begin
        STALL_COUNT <= STALL_COUNT + 16'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// Testbench for dmem_block_responder. Drives directed vectors with hand-computed
// expected values into a LATENCY=5 instance and a LATENCY=1 instance.
module tb_dmem_block_responder;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;

  logic        rst1;
  logic        rd1;
  logic        wr1;
  logic [5:0]  addr1;
  logic [31:0] wdata1;
  logic [31:0] rdata1;
  logic        busy1;

  int checks;
  int errors;

`ifdef DMEM_STATS_EN
  logic [15:0] rdCount;
  logic [15:0] wrCount;
  logic [15:0] stallCount;
  logic [15:0] rdCount1;
  logic [15:0] wrCount1;
  logic [15:0] stallCount1;
`endif

  dmem_block_responder #(.LATENCY(5), .BLOCK_ADDR_W(6)) dut5 (
    .CLK(clk), .RESET(rst), .READ(rd), .WRITE(wr), .ADDRESS(addr),
    .WRITEDATA(wdata), .READDATA(rdata), .BUSYWAIT(busy)
`ifdef DMEM_STATS_EN
    , .RD_COUNT(rdCount), .WR_COUNT(wrCount), .STALL_COUNT(stallCount)
`endif
  );

  dmem_block_responder #(.LATENCY(1), .BLOCK_ADDR_W(6)) dut1 (
    .CLK(clk), .RESET(rst1), .READ(rd1), .WRITE(wr1), .ADDRESS(addr1),
    .WRITEDATA(wdata1), .READDATA(rdata1), .BUSYWAIT(busy1)
`ifdef DMEM_STATS_EN
    , .RD_COUNT(rdCount1), .WR_COUNT(wrCount1), .STALL_COUNT(stallCount1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=5 instance. The request is raised at a negedge,
  // and busy is sampled 1 time unit after each later negedge. When busy first reads
  // low, the DUT is in DONE and the returned data is sampled. If altAt is nonzero,
  // the address is switched to altAddr once that many busy cycles have been seen.
  task automatic applyStimulus(input string tag, input logic r, input logic w,
                               input logic [5:0] a, input logic [31:0] d,
                               input int altAt, input logic [5:0] altAddr,
                               output logic [31:0] data, output int busyCycles);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
    busyCycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busyCycles++;
      if (busyCycles == altAt) addr = altAddr;
      @(negedge clk);
      #1;
    end
    checkOutput({tag, "_done"}, {31'h0, busy}, 32'h0);
    data = rdata;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    #1;
  endtask

  logic [31:0] data;
  int          cyc;
  logic [8:0]  pattern;

  initial begin
    checks = 0; errors = 0;
    rd = 0; wr = 0; addr = 0; wdata = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    rst = 1; rst1 = 1;
    repeat (2) @(negedge clk);
    rst = 0; rst1 = 0;
    repeat (3) @(negedge clk);

    // Reset pulse mid-simulation with a read request already raised.
    rst = 1; rd = 1; addr = 6'h05;
    #1;
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rst_busy2", {31'h0, busy}, 32'h0);
    rd = 0;
    rst = 0;
    @(negedge clk);

    // Read of a cleared block takes LATENCY+1 busy cycles.
    applyStimulus("rd05", 1, 0, 6'h05, 32'h0, 0, 6'h0, data, cyc);
    checkOutput("rd05_data", data, 32'h0);
    checkOutput("rd05_cycles", cyc, 32'd6);

    // A write leaves READDATA unchanged.
    applyStimulus("wr06", 0, 1, 6'h06, 32'h0A0C16F7, 0, 6'h0, data, cyc);
    checkOutput("wr06_rdata", data, 32'h0);
    checkOutput("wr06_cycles", cyc, 32'd6);
    applyStimulus("rd06", 1, 0, 6'h06, 32'h0, 0, 6'h0, data, cyc);
    checkOutput("rd06_data", data, 32'h0A0C16F7);

    // Changing the address mid-access does not affect the captured address.
    applyStimulus("wr0e", 0, 1, 6'h0E, 32'h11223344, 0, 6'h0, data, cyc);
    checkOutput("wr0e_rdata", data, 32'h0A0C16F7);
    applyStimulus("rdchg", 1, 0, 6'h06, 32'h0, 3, 6'h0E, data, cyc);
    checkOutput("rdchg_data", data, 32'h0A0C16F7);
    applyStimulus("rd0e", 1, 0, 6'h0E, 32'h0, 0, 6'h0, data, cyc);
    checkOutput("rd0e_data", data, 32'h11223344);

    // READ and WRITE together are treated as a read, and memory is unchanged.
    applyStimulus("both", 1, 1, 6'h06, 32'hFFFFFFFF, 0, 6'h0, data, cyc);
    checkOutput("both_data", data, 32'h0A0C16F7);
    applyStimulus("rd06b", 1, 0, 6'h06, 32'h0, 0, 6'h0, data, cyc);
    checkOutput("rd06b_data", data, 32'h0A0C16F7);

`ifdef DMEM_STATS_EN
    // 6 reads, 2 writes, 8 transactions of 6 stalled edges each.
    checkOutput("rd_count", {16'h0, rdCount}, 32'd6);
    checkOutput("wr_count", {16'h0, wrCount}, 32'd2);
    checkOutput("stall_count", {16'h0, stallCount}, 32'd48);
`endif

    // Reset two cycles after a write is captured aborts the write.
    @(negedge clk);
    wr = 1; addr = 6'h10; wdata = 32'h12345678;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    checkOutput("rstmid_busy", {31'h0, busy}, 32'h0);
    checkOutput("rstmid_rdata", rdata, 32'h0);
    wr = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    applyStimulus("rd10", 1, 0, 6'h10, 32'h0, 0, 6'h0, data, cyc);
    checkOutput("rd10_data", data, 32'h0);
    applyStimulus("rd06c", 1, 0, 6'h06, 32'h0, 0, 6'h0, data, cyc);
    checkOutput("rd06c_cleared", data, 32'h0);
`ifdef DMEM_STATS_EN
    checkOutput("rd_count_rst", {16'h0, rdCount}, 32'd2);
    checkOutput("wr_count_rst", {16'h0, wrCount}, 32'd0);
`endif

    // LATENCY=1 instance: write block 3, then hold READ across DONE.
    @(negedge clk);
    wr1 = 1; addr1 = 6'h03; wdata1 = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    wr1 = 0;
    @(negedge clk);
    rd1 = 1; addr1 = 6'h03;
    pattern = 9'h0;
    for (int i = 0; i < 9; i++) begin
      #1;
      pattern[8 - i] = busy1;
      if (i == 2) checkOutput("b2b_data", rdata1, 32'hCAFEF00D);
      if (i == 8) rd1 = 0;
      @(negedge clk);
    end
    checkOutput("b2b_pattern", {23'h0, pattern}, {23'h0, 9'b110110110});
`ifdef DMEM_STATS_EN
    // 1 write and 3 reads, 2 stalled edges each.
    checkOutput("b2b_stall", {16'h0, stallCount1}, 32'd8);
    checkOutput("b2b_rd", {16'h0, rdCount1}, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
